// File: rtl/cnn_pkg.sv
// cnn_pkg: frame geometry, pixel type and window FSM states shared by the window generator.
package cnn_pkg;

    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int K       = 5;
    localparam int DATA_W  = 8;
    localparam int COL_W   = $clog2(IMG_W);
    localparam int ROW_W   = $clog2(IMG_H);
    localparam int COORD_W = $clog2(IMG_W - K + 1);

    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} win_state_t;

endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-deep pixel delay built as a circular buffer; advances only when i_shift is high.
module line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = IMG_W
) (
    input  logic   i_sys_clk,
    input  logic   i_rst,
    input  logic   i_shift,
    input  pixel_t i_pixel,
    output pixel_t o_pixel
);

    localparam int AW = $clog2(DEPTH);

    pixel_t        mem [DEPTH];
    logic [AW-1:0] ptr;

    // Slot under ptr was written DEPTH shifts ago, so it is both the output and the write target.
    assign o_pixel = mem[ptr];

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) ptr <= '0;
        else if (i_shift) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_shift) mem[ptr] <= i_pixel;
    end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: KxK sliding-window generator over a raster pixel stream with window backpressure.
// Define WINDOW_COORD_EN to add o_win_row/o_win_col (top-left coordinate of the current window).
module conv_window_gen
    import cnn_pkg::*;
(
    input  logic                  i_sys_clk,
    input  logic                  i_rst,
    input  logic                  i_feature_valid,
    input  pixel_t                i_feature,
    output logic                  o_rd_en,
    output logic                  o_window_valid,
    output logic [K*K*DATA_W-1:0] o_window,
    input  logic                  i_window_ready,
`ifdef WINDOW_COORD_EN
    output logic [COORD_W-1:0]    o_win_row,
    output logic [COORD_W-1:0]    o_win_col,
`endif
    output logic                  o_frame_done
);

    win_state_t            state;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic                  accept, col_last, row_last, completes;
    logic [K*K*DATA_W-1:0] win_next;
    pixel_t                chain [K];

    assign o_rd_en   = !o_window_valid || i_window_ready;
    assign accept    = i_feature_valid && o_rd_en;
    assign col_last  = col == COL_W'(IMG_W - 1);
    assign row_last  = row == ROW_W'(IMG_H - 1);
    assign completes = row >= ROW_W'(K - 1) && col >= COL_W'(K - 1);

    // chain[0] is the live pixel, chain[K-1] the pixel from K-1 rows above.
    assign chain[0] = i_feature;

    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        line_buffer #(.DEPTH(IMG_W)) u_lb (
            .i_sys_clk(i_sys_clk),
            .i_rst    (i_rst),
            .i_shift  (accept),
            .i_pixel  (chain[g]),
            .o_pixel  (chain[g+1])
        );
    end

    always_comb begin
        win_next = o_window;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++)
                win_next[(r*K+c)*DATA_W +: DATA_W] = o_window[(r*K+c+1)*DATA_W +: DATA_W];
            win_next[(r*K+K-1)*DATA_W +: DATA_W] = chain[K-1-r];
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            col            <= '0;
            row            <= '0;
            o_window_valid <= 1'b0;
            o_window       <= '0;
            o_frame_done   <= 1'b0;
        end else begin
            o_frame_done <= state == STREAM && accept && col_last && row_last;
            if (accept) begin
                o_window       <= win_next;
                o_window_valid <= completes;
                col            <= col_last ? '0 : col + 1'b1;
                row            <= col_last ? (row_last ? '0 : row + 1'b1) : row;
            end else if (i_window_ready) begin
                o_window_valid <= 1'b0;
            end
            case (state)
                IDLE:    state <= accept ? FILL : IDLE;
                FILL:    state <= (accept && col_last && row == ROW_W'(K - 2)) ? STREAM : FILL;
                STREAM:  state <= (accept && col_last && row_last) ? DONE : STREAM;
                default: state <= accept ? FILL : IDLE;
            endcase
        end
    end

`ifdef WINDOW_COORD_EN
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            o_win_row <= '0;
            o_win_col <= '0;
        end else if (accept && completes) begin
            o_win_row <= COORD_W'(row - ROW_W'(K - 1));
            o_win_col <= COORD_W'(col - COL_W'(K - 1));
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: random-stimulus bench comparing windows against a frame-array neighbourhood model.
module tb_conv_window_gen;
    import cnn_pkg::*;

    localparam int WW = K*K*DATA_W;
    localparam int NW = (IMG_W-K+1)*(IMG_H-K+1);

    logic          i_sys_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_feature_valid = 1'b0;
    logic          i_window_ready = 1'b0;
    pixel_t        i_feature = '0;
    logic          o_rd_en, o_window_valid, o_frame_done;
    logic [WW-1:0] o_window;
`ifdef WINDOW_COORD_EN
    logic [COORD_W-1:0] o_win_row, o_win_col;
`endif

    typedef struct { logic [WW-1:0] w; int r; int c; } win_t;

    pixel_t        src[$];
    win_t          exp_q[$];
    int            n_chk = 0, n_pass = 0;
    int            acc, got, dones, cyc = 0, gap;
    bit            seen, stalled;
    logic [WW-1:0] held;

    conv_window_gen dut (
        .i_sys_clk      (i_sys_clk),
        .i_rst          (i_rst),
        .i_feature_valid(i_feature_valid),
        .i_feature      (i_feature),
        .o_rd_en        (o_rd_en),
        .o_window_valid (o_window_valid),
        .o_window       (o_window),
        .i_window_ready (i_window_ready),
`ifdef WINDOW_COORD_EN
        .o_win_row      (o_win_row),
        .o_win_col      (o_win_col),
`endif
        .o_frame_done   (o_frame_done)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    // Reference: every window is read straight out of the whole frame array.
    task automatic add_frame(input int pat);
        pixel_t f [IMG_W*IMG_H];
        win_t   e;
        for (int i = 0; i < IMG_W*IMG_H; i++) begin
            f[i] = (pat == 0) ? pixel_t'(i) : pixel_t'($urandom);
            src.push_back(f[i]);
        end
        for (int wr = 0; wr <= IMG_H-K; wr++)
            for (int wc = 0; wc <= IMG_W-K; wc++) begin
                e.w = '0;
                e.r = wr;
                e.c = wc;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        e.w[(r*K+c)*DATA_W +: DATA_W] = f[(wr+r)*IMG_W + wc + c];
                exp_q.push_back(e);
            end
    endtask

    task automatic step(input int rmode, input int gmode);
        @(negedge i_sys_clk);
        cyc++;
        i_window_ready = (rmode == 1) ? ((cyc / 10) % 2 == 0) : 1'b1;
        if (gap > 0) begin
            gap--;
            i_feature_valid = 1'b0;
        end else begin
            i_feature_valid = src.size() > 0;
            if (gmode == 1 && $urandom_range(0, 7) == 0) begin
                gap = $urandom_range(0, 4);
                i_feature_valid = 1'b0;
            end
        end
        i_feature = (src.size() > 0) ? src[0] : '0;
        #1;
        check("rd_en", o_rd_en, !o_window_valid || i_window_ready);
        if (o_window_valid && !i_window_ready) check("stall_rd_en", o_rd_en, 0);
        if (stalled && o_window_valid) check("stall_hold", o_window, held);
        stalled = o_window_valid && !i_window_ready;
        held = o_window;
        if (o_frame_done) begin
            dones++;
            check("done_pos", o_window_valid && (got % NW == NW-1), 1);
        end
        if (o_window_valid && !seen) begin
            seen = 1;
            check("first_lat", acc, (K-1)*IMG_W + K);
        end
        if (o_window_valid) begin
            if (exp_q.size() == 0) check("extra_window", 1, 0);
            else begin
                check("window", o_window, exp_q[0].w);
`ifdef WINDOW_COORD_EN
                check("win_row", o_win_row, exp_q[0].r);
                check("win_col", o_win_col, exp_q[0].c);
`endif
                if (i_window_ready) begin
                    void'(exp_q.pop_front());
                    got++;
                end
            end
        end
        if (i_feature_valid && o_rd_en) begin
            void'(src.pop_front());
            acc++;
        end
    endtask

    task automatic run(input int nf, input int pat, input int rmode, input int gmode, input int abort_at);
        acc = 0; got = 0; dones = 0; gap = 0; seen = 0; stalled = 0;
        src.delete();
        exp_q.delete();
        for (int f = 0; f < nf; f++) add_frame(pat);
        for (int t = 0; t < 20000; t++) begin
            if (exp_q.size() == 0 && src.size() == 0) break;
            if (abort_at > 0 && acc > abort_at) break;
            step(rmode, gmode);
        end
        if (abort_at == 0) begin
            check("budget", exp_q.size() + src.size(), 0);
            check("win_count", got, nf*NW);
            check("done_count", dones, nf);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, o_window_valid, 0);
        check({tag, "_window"}, o_window, 0);
        check({tag, "_done"}, o_frame_done, 0);
        check({tag, "_rd_en"}, o_rd_en, 1);
`ifdef WINDOW_COORD_EN
        check({tag, "_row"}, o_win_row, 0);
        check({tag, "_col"}, o_win_col, 0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge i_sys_clk);
        #1;
        check_reset_state("reset");
        i_rst = 1'b0;
        run(1, 0, 0, 0, 0);
        run(1, 1, 1, 0, 0);
        run(1, 0, 0, 1, 0);
        run(1, 1, 1, 1, 0);
        run(1, 1, 0, 0, 300);
        @(negedge i_sys_clk);
        i_rst = 1'b1;
        i_feature_valid = 1'b0;
        @(negedge i_sys_clk);
        #1;
        check_reset_state("midrst");
        i_rst = 1'b0;
        run(1, 1, 0, 0, 0);
        run(2, 1, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
